// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The optional illegal-opcode trap is enabled with ILLEGAL_TRAP_EN.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JMP      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_NONE  = 3'b000;
  localparam logic [2:0] IMM_I     = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_J     = 3'b101;
  localparam logic [2:0] IMM_SHAMT = 3'b110;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retired;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // States that wait on MemReady and therefore feed the timeout counter.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle; master = controller side.
// Carries the Illegal flag only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_fsm_if;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       Retired;
  logic       BusErr;
`ifdef ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  modport master (
    input  Op, Funct3, Funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Retired, BusErr
`ifdef ILLEGAL_TRAP_EN
           , Illegal
`endif
  );

  modport slave (
    output Op, Funct3, Funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Retired, BusErr
`ifdef ILLEGAL_TRAP_EN
           , Illegal
`endif
  );
endinterface

// File: rtl/multicycle_control_fsm_next_state.sv
// Combinational next-state and ImmSrc decode for the multicycle controller.
// ILLEGAL_TRAP_EN routes unknown opcodes to TRAP instead of back to FETCH.
module mc_next_state
  import riscv_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_mem_ready,
  output state_t     o_next,
  output logic [2:0] o_imm_src
);

  // Instruction sequencing (timeout override is applied by the top).
  always_comb begin
    o_next = S_FETCH;
    case (i_state)
      S_FETCH:    o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: o_next = S_MEMADR;
          OP_RTYPE:          o_next = S_EXECR;
          OP_ITYPE:          o_next = S_EXECI;
          OP_BRANCH:         o_next = S_BRANCH;
          OP_JAL:            o_next = S_JMP;
          OP_JALR:           o_next = S_JALR;
          OP_LUI:            o_next = S_LUI;
          OP_AUIPC:          o_next = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           o_next = S_TRAP;
`else
          default:           o_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   o_next = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  o_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    o_next = S_FETCH;
      S_MEMWRITE: o_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: o_next = S_ALUWB;
      S_ALUWB, S_BRANCH: o_next = S_FETCH;
      S_JALR:     o_next = S_JMP;
      S_JMP:      o_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     o_next = S_TRAP;
`else
      S_TRAP:     o_next = S_FETCH;
`endif
      default:    o_next = S_FETCH;
    endcase
  end

  // Immediate format for the states that consume ImmExt.
  always_comb begin
    o_imm_src = IMM_NONE;
    case (i_state)
      S_DECODE: o_imm_src = (i_op == OP_JAL) ? IMM_J : IMM_B;
      S_MEMADR: o_imm_src = (i_op == OP_STORE) ? IMM_S : IMM_I;
      S_EXECI:  o_imm_src = ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) ? IMM_SHAMT : IMM_I;
      S_JALR:   o_imm_src = IMM_I;
      S_LUI, S_AUIPC: o_imm_src = IMM_U;
      default:  o_imm_src = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing controller: state, memory-wait timeout, BusErr, output decode.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes and expose the Illegal flag.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     r_state;
  state_t     w_ns_raw;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_bus_err;
  logic       w_timeout;
  logic [2:0] w_imm_src;
  logic [2:0] w_imm_out;
  ctrl_t      w_ctrl;
  logic       w_illegal;

  // The limit cycle is the WAIT_LIMIT-th consecutive stall; a ready in that cycle still wins.
  assign w_timeout = is_mem_wait_state(r_state) && !bus.MemReady && (r_wait_cnt == LIMIT_M1);

  mc_next_state u_next_state (
    .i_state     (r_state),
    .i_op        (bus.Op),
    .i_funct3    (bus.Funct3),
    .i_mem_ready (bus.MemReady),
    .o_next      (w_ns_raw),
    .o_imm_src   (w_imm_src)
  );

  // Next state with the bus-timeout abort folded in.
  always_comb begin
    if (w_timeout) begin
      w_next = S_FETCH;
    end else begin
      w_next = w_ns_raw;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Consecutive memory-stall counter; any state change or timeout restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_timeout || (w_next != r_state)) begin
      r_wait_cnt <= 8'd0;
    end else if (is_mem_wait_state(r_state) && !bus.MemReady) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Sticky bus-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end else begin
      r_bus_err <= r_bus_err;
    end
  end

  // Moore output decode; reset zeroes everything, a timeout cycle suppresses strobes.
  always_comb begin
    w_ctrl    = '0;
    w_imm_out = IMM_NONE;
    w_illegal = 1'b0;
    if (!rst_n) begin
      w_ctrl    = '0;
      w_imm_out = IMM_NONE;
      w_illegal = 1'b0;
    end else begin
      w_imm_out = w_imm_src;
      case (r_state)
        S_FETCH: begin
          w_ctrl.alu_src_b  = SRCB_FOUR;
          w_ctrl.result_src = RES_ALURESULT;
          w_ctrl.ir_write   = bus.MemReady;
          w_ctrl.pc_write   = bus.MemReady;
        end
        S_DECODE: begin
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_IMM;
`ifdef ILLEGAL_TRAP_EN
          w_ctrl.retired   = 1'b0;
`else
          w_ctrl.retired   = !is_legal_op(bus.Op);
`endif
        end
        S_MEMADR, S_JALR: begin
          w_ctrl.alu_src_a = SRCA_RD1;
          w_ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          w_ctrl.adr_src = 1'b1;
        end
        S_MEMWB: begin
          w_ctrl.result_src = RES_DATA;
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.retired    = 1'b1;
        end
        S_MEMWRITE: begin
          w_ctrl.adr_src   = 1'b1;
          w_ctrl.mem_write = 1'b1;
          w_ctrl.retired   = bus.MemReady;
        end
        S_EXECR: begin
          w_ctrl.alu_src_a = SRCA_RD1;
          w_ctrl.alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          w_ctrl.alu_src_a = SRCA_RD1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.retired   = 1'b1;
        end
        S_BRANCH: begin
          w_ctrl.alu_src_a = SRCA_RD1;
          w_ctrl.alu_op    = ALU_SUB;
          w_ctrl.pc_write  = bus.Zero ^ bus.Funct3[0];
          w_ctrl.retired   = 1'b1;
        end
        S_JMP: begin
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_FOUR;
          w_ctrl.pc_write  = 1'b1;
        end
        S_LUI: begin
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.alu_op    = ALU_PASSB;
        end
        S_AUIPC: begin
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_IMM;
        end
        S_TRAP: begin
          w_illegal = 1'b1;
        end
        default: begin
          w_ctrl = '0;
        end
      endcase
      w_ctrl.pc_write  = w_ctrl.pc_write  & ~w_timeout;
      w_ctrl.ir_write  = w_ctrl.ir_write  & ~w_timeout;
      w_ctrl.mem_write = w_ctrl.mem_write & ~w_timeout;
      w_ctrl.reg_write = w_ctrl.reg_write & ~w_timeout;
      w_ctrl.retired   = w_ctrl.retired   & ~w_timeout;
    end
  end

  assign bus.PCWrite   = w_ctrl.pc_write;
  assign bus.AdrSrc    = w_ctrl.adr_src;
  assign bus.MemWrite  = w_ctrl.mem_write;
  assign bus.IRWrite   = w_ctrl.ir_write;
  assign bus.RegWrite  = w_ctrl.reg_write;
  assign bus.ResultSrc = w_ctrl.result_src;
  assign bus.ALUSrcA   = w_ctrl.alu_src_a;
  assign bus.ALUSrcB   = w_ctrl.alu_src_b;
  assign bus.ALUOp     = w_ctrl.alu_op;
  assign bus.ImmSrc    = w_imm_out;
  assign bus.Retired   = w_ctrl.retired;
  assign bus.BusErr    = r_bus_err;
`ifdef ILLEGAL_TRAP_EN
  assign bus.Illegal   = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: vector table, corner sequences and
// randomized instruction streams checked against an instruction-level reference model.
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  localparam int WAIT_LIMIT = 16;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sampled outputs of the current cycle; sel = {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc}.
  logic        s_pc, s_ir, s_mw, s_rw, s_ret, s_be, s_ill;
  logic [11:0] s_sel;
  logic        tr_pc [64], tr_ir [64], tr_mw [64], tr_rw [64], tr_ret [64], tr_be [64];
  logic [11:0] tr_sel [64];

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic [2:0] imm3;
    logic [1:0] aluop3;
    logic [1:0] srcb3;
    logic       pc3;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic int ref_latency(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_JALR:                      return 5;
      OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL,
      OP_LUI, OP_AUIPC:                      return 4;
      OP_BRANCH:                             return 3;
      default:                               return 2;
    endcase
  endfunction

  function automatic bit is_memop(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic int ref_regwrites(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_RTYPE || op == OP_ITYPE || op == OP_LUI ||
            op == OP_AUIPC || op == OP_JAL || op == OP_JALR) ? 1 : 0;
  endfunction

  function automatic int ref_pcwrites(input logic [6:0] op, input logic [2:0] f3, input logic z);
    int n = 1;
    if (op == OP_BRANCH) n += int'(z ^ f3[0]);
    if (op == OP_JAL || op == OP_JALR) n += 1;
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cycle(input logic r, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input logic mr);
    @(negedge clk);
    rst_n        = r;
    bus.Op       = op;
    bus.Funct3   = f3;
    bus.Funct7b5 = 1'($urandom);
    bus.Zero     = z;
    bus.MemReady = mr;
    #1;
    s_pc  = bus.PCWrite;
    s_ir  = bus.IRWrite;
    s_mw  = bus.MemWrite;
    s_rw  = bus.RegWrite;
    s_ret = bus.Retired;
    s_be  = bus.BusErr;
    s_sel = {bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc};
`ifdef ILLEGAL_TRAP_EN
    s_ill = bus.Illegal;
`else
    s_ill = 1'b0;
`endif
  endtask

  // Stalls fetch for fs cycles and the memory phase for ms cycles; MemReady is random elsewhere.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fs, input int ms, output int total);
    int   mem_start;
    logic mr;
    total     = ref_latency(op) + fs + (is_memop(op) ? ms : 0);
    mem_start = fs + 3;
    for (int c = 0; c < total; c++) begin
      if (c < fs) mr = 1'b0;
      else if (c == fs) mr = 1'b1;
      else if (is_memop(op) && c >= mem_start && c < mem_start + ms) mr = 1'b0;
      else if (is_memop(op) && c == mem_start + ms) mr = 1'b1;
      else mr = 1'($urandom);
      drive_cycle(1'b1, op, f3, z, mr);
      tr_pc[c] = s_pc;  tr_ir[c] = s_ir;  tr_mw[c] = s_mw;
      tr_rw[c] = s_rw;  tr_ret[c] = s_ret; tr_be[c] = s_be; tr_sel[c] = s_sel;
    end
  endtask

  task automatic check_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input int fs, input int ms);
    int total, n_ret, ret_at, n_ir, n_pc, n_rw, n_mw;
    run_instr(op, f3, z, fs, ms, total);
    n_ret = 0; ret_at = -1; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0;
    for (int c = 0; c < total; c++) begin
      if (tr_ret[c]) begin n_ret++; ret_at = c; end
      n_ir += int'(tr_ir[c]);
      n_pc += int'(tr_pc[c]);
      n_rw += int'(tr_rw[c]);
      n_mw += int'(tr_mw[c]);
    end
    chk({name, " retire_cycle"}, ret_at + 1, total);
    chk({name, " retire_count"}, n_ret, 1);
    chk({name, " irwrite_count"}, n_ir, 1);
    chk({name, " pcwrite_count"}, n_pc, ref_pcwrites(op, f3, z));
    chk({name, " regwrite_count"}, n_rw, ref_regwrites(op));
    chk({name, " memwrite_count"}, n_mw, (op == OP_STORE) ? ms + 1 : 0);
    chk({name, " buserr"}, int'(tr_be[total-1]), 0);
  endtask

  vec_t vt [13];
  logic [6:0] rnd_ops [9];

  initial begin
    int n_mw, n_ret, n_ir, n_ill, fs, ms;
    logic [6:0] op;

    vt[0]  = '{"lw",    OP_LOAD,   3'b010, 1'b0, 3'b001, 2'b00, 2'b01, 1'b0};
    vt[1]  = '{"sw",    OP_STORE,  3'b010, 1'b0, 3'b010, 2'b00, 2'b01, 1'b0};
    vt[2]  = '{"add",   OP_RTYPE,  3'b000, 1'b0, 3'b000, 2'b10, 2'b00, 1'b0};
    vt[3]  = '{"addi",  OP_ITYPE,  3'b000, 1'b0, 3'b001, 2'b10, 2'b01, 1'b0};
    vt[4]  = '{"slli",  OP_ITYPE,  3'b001, 1'b0, 3'b110, 2'b10, 2'b01, 1'b0};
    vt[5]  = '{"srai",  OP_ITYPE,  3'b101, 1'b1, 3'b110, 2'b10, 2'b01, 1'b0};
    vt[6]  = '{"beq_z1", OP_BRANCH, 3'b000, 1'b1, 3'b000, 2'b01, 2'b00, 1'b1};
    vt[7]  = '{"bne_z1", OP_BRANCH, 3'b001, 1'b1, 3'b000, 2'b01, 2'b00, 1'b0};
    vt[8]  = '{"bne_z0", OP_BRANCH, 3'b001, 1'b0, 3'b000, 2'b01, 2'b00, 1'b1};
    vt[9]  = '{"jal",   OP_JAL,    3'b000, 1'b0, 3'b000, 2'b00, 2'b10, 1'b1};
    vt[10] = '{"jalr",  OP_JALR,   3'b000, 1'b0, 3'b001, 2'b00, 2'b01, 1'b0};
    vt[11] = '{"lui",   OP_LUI,    3'b000, 1'b0, 3'b100, 2'b11, 2'b01, 1'b0};
    vt[12] = '{"auipc", OP_AUIPC,  3'b000, 1'b0, 3'b100, 2'b00, 2'b01, 1'b0};
    rnd_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Reset held three cycles with MemReady=1: everything quiet.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
      chk("reset_strobes", int'({s_pc, s_ir, s_mw, s_rw, s_ret}), 0);
      chk("reset_selects", int'(s_sel), 0);
    end
    drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("release_pcwrite", int'(s_pc), 1);
    chk("release_irwrite", int'(s_ir), 1);
    chk("release_buserr", int'(s_be), 0);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("reset_in_decode_strobes", int'({s_pc, s_ir, s_mw, s_rw, s_ret}), 0);

    // Table: one instruction each, MemReady=1 on the memory cycles.
    foreach (vt[k]) begin
      check_instr(vt[k].name, vt[k].op, vt[k].f3, vt[k].z, 0, 0);
      chk({vt[k].name, " decode_imm"}, int'(tr_sel[1][2:0]), (vt[k].op == OP_JAL) ? 5 : 3);
      chk({vt[k].name, " c3_imm"},   int'(tr_sel[2][2:0]), int'(vt[k].imm3));
      chk({vt[k].name, " c3_aluop"}, int'(tr_sel[2][4:3]), int'(vt[k].aluop3));
      chk({vt[k].name, " c3_srcb"},  int'(tr_sel[2][6:5]), int'(vt[k].srcb3));
      chk({vt[k].name, " c3_pcwrite"}, int'(tr_pc[2]), int'(vt[k].pc3));
    end

    // Store stalled WAIT_LIMIT cycles: timeout, no strobe in the limit cycle.
    drive_cycle(1'b1, OP_STORE, 3'b010, 1'b0, 1'b1);
    drive_cycle(1'b1, OP_STORE, 3'b010, 1'b0, 1'($urandom));
    drive_cycle(1'b1, OP_STORE, 3'b010, 1'b0, 1'($urandom));
    n_mw = 0; n_ret = 0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      drive_cycle(1'b1, OP_STORE, 3'b010, 1'b0, 1'b0);
      n_mw  += int'(s_mw);
      n_ret += int'(s_ret);
    end
    chk("sw_timeout_memwrite", n_mw, WAIT_LIMIT - 1);
    chk("sw_timeout_retired", n_ret, 0);
    chk("sw_timeout_buserr_before", int'(s_be), 0);
    drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("after_timeout_fetch_irwrite", int'(s_ir), 1);
    chk("after_timeout_buserr", int'(s_be), 1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'($urandom));
    chk("sticky_addi_retired", int'(s_ret), 1);
    chk("sticky_buserr", int'(s_be), 1);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("reset_clears_buserr", int'(s_be), 0);

    // Fetch stalled WAIT_LIMIT cycles also times out.
    n_ir = 0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'b0);
      n_ir += int'(s_ir);
    end
    chk("fetch_timeout_irwrite", n_ir, 0);
    drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("fetch_timeout_buserr", int'(s_be), 1);
    chk("fetch_timeout_refetch", int'(s_ir), 1);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);

    // Ready arriving in the limit cycle wins.
    check_instr("sw_ready_at_limit", OP_STORE, 3'b010, 1'b0, 0, WAIT_LIMIT - 1);
    check_instr("lw_ready_at_limit", OP_LOAD, 3'b010, 1'b0, WAIT_LIMIT - 1, WAIT_LIMIT - 1);

    // Reset in the load write-back cycle aborts it.
    drive_cycle(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b1);
    drive_cycle(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b0);
    drive_cycle(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b0);
    drive_cycle(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b1);
    drive_cycle(1'b0, OP_LOAD, 3'b010, 1'b0, 1'b1);
    chk("abort_memwb_regwrite", int'(s_rw), 0);
    chk("abort_memwb_retired", int'(s_ret), 0);
    check_instr("addi_after_abort", OP_ITYPE, 3'b000, 1'b0, 0, 0);

    // Illegal opcode.
`ifdef ILLEGAL_TRAP_EN
    drive_cycle(1'b1, OP_ILL, 3'b000, 1'b0, 1'b1);
    drive_cycle(1'b1, OP_ILL, 3'b000, 1'b0, 1'b1);
    chk("illegal_decode_retired", int'(s_ret), 0);
    n_ill = 0; n_ir = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, OP_ITYPE, 3'b000, 1'b0, 1'b1);
      n_ill += int'(s_ill);
      n_ir  += int'(s_ir | s_pc | s_rw | s_mw | s_ret);
    end
    chk("trap_illegal_cycles", n_ill, 5);
    chk("trap_strobes", n_ir, 0);
    drive_cycle(1'b0, OP_ITYPE, 3'b000, 1'b0, 1'b1);
    chk("trap_reset_illegal", int'(s_ill), 0);
`else
    n_ill = 0;
    check_instr("illegal_nop", OP_ILL, 3'b000, 1'b0, 0, 0);
    chk("illegal_nop_flag", int'(s_ill), n_ill);
`endif
    check_instr("addi_after_illegal", OP_ITYPE, 3'b000, 1'b0, 0, 0);

    // Random instruction stream against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = rnd_ops[$urandom_range(0, 8)];
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 2);
      ms = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 2);
      check_instr("rand", op, 3'($urandom), 1'($urandom), fs, ms);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
